// File: rtl/rv_id_ctrl.sv
// Decode-stage controller for the RV32I pipeline: instruction decode, load-use
// hazard and flush recovery sequencing, and the registered ID/EX control bundle.

package rv_id_ctrl_pkg;
    typedef enum logic [1:0] {
        IMM_U = 2'd0,
        IMM_I = 2'd1,
        IMM_S = 2'd2,
        IMM_B = 2'd3
    } immext_ctrl_e;
endpackage

module rv_id_ctrl
    import rv_id_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [31:0]      i_id_instr,
    input  logic             i_ex_hold,
    input  logic             i_flush,
    output immext_ctrl_e     o_id_immext_ctrl,
    output logic             o_stall_ifid,
    output logic             o_illegal,
    output logic             o_ex_valid,
    output logic [4:0]       o_ex_rd,
    output logic [4:0]       o_ex_rs1,
    output logic [4:0]       o_ex_rs2,
    output logic [2:0]       o_ex_funct3,
    output logic             o_ex_reg_we,
    output logic             o_ex_mem_re,
    output logic             o_ex_mem_we,
    output logic             o_ex_alu_imm,
    output logic             o_ex_is_branch,
    output logic             o_ex_is_jalr,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_flush_cnt_nxt;

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [2:0] w_funct3;

    logic w_known;
    logic w_rs1_used;
    logic w_rs2_used;
    logic w_dec_reg_we;
    logic w_dec_mem_re;
    logic w_dec_mem_we;
    logic w_dec_alu_imm;
    logic w_dec_branch;
    logic w_dec_jalr;

    logic w_id_valid;
    logic w_illegal;
    logic w_issue;
    logic w_hazard;
    logic w_advance;
    logic w_load;

    assign w_opcode = i_id_instr[6:0];
    assign w_rd     = i_id_instr[11:7];
    assign w_funct3 = i_id_instr[14:12];
    assign w_rs1    = i_id_instr[19:15];
    assign w_rs2    = i_id_instr[24:20];

    // Opcode decode: immediate format, operand usage and control bits
    always_comb begin
        w_known          = 1'b0;
        w_rs1_used       = 1'b0;
        w_rs2_used       = 1'b0;
        w_dec_reg_we     = 1'b0;
        w_dec_mem_re     = 1'b0;
        w_dec_mem_we     = 1'b0;
        w_dec_alu_imm    = 1'b0;
        w_dec_branch     = 1'b0;
        w_dec_jalr       = 1'b0;
        o_id_immext_ctrl = IMM_U;
        case (w_opcode)
            OP_LOAD: begin
                w_known          = 1'b1;
                w_rs1_used       = 1'b1;
                w_dec_reg_we     = 1'b1;
                w_dec_mem_re     = 1'b1;
                w_dec_alu_imm    = 1'b1;
                o_id_immext_ctrl = IMM_I;
            end
            OP_IMM: begin
                w_known          = 1'b1;
                w_rs1_used       = 1'b1;
                w_dec_reg_we     = 1'b1;
                w_dec_alu_imm    = 1'b1;
                o_id_immext_ctrl = IMM_I;
            end
            OP_AUIPC, OP_LUI: begin
                w_known       = 1'b1;
                w_dec_reg_we  = 1'b1;
                w_dec_alu_imm = 1'b1;
            end
            OP_STORE: begin
                w_known          = 1'b1;
                w_rs1_used       = 1'b1;
                w_rs2_used       = 1'b1;
                w_dec_mem_we     = 1'b1;
                w_dec_alu_imm    = 1'b1;
                o_id_immext_ctrl = IMM_S;
            end
            OP_OP: begin
                w_known      = 1'b1;
                w_rs1_used   = 1'b1;
                w_rs2_used   = 1'b1;
                w_dec_reg_we = 1'b1;
            end
            OP_BRANCH: begin
                w_known          = 1'b1;
                w_rs1_used       = 1'b1;
                w_rs2_used       = 1'b1;
                w_dec_branch     = 1'b1;
                o_id_immext_ctrl = IMM_B;
            end
            OP_JALR: begin
                w_known          = 1'b1;
                w_rs1_used       = 1'b1;
                w_dec_reg_we     = 1'b1;
                w_dec_alu_imm    = 1'b1;
                w_dec_jalr       = 1'b1;
                o_id_immext_ctrl = IMM_I;
            end
            OP_JAL: begin
                w_known = 1'b1;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    // While recovering from a flush the IF/ID contents are stale refetch slots
    assign w_id_valid = i_id_valid & (r_state != ST_FLUSH);
    assign w_illegal  = w_id_valid & ~w_known;
    assign w_issue    = w_id_valid & w_known & (w_opcode != OP_JAL);
    assign w_hazard   = o_ex_valid & o_ex_mem_re & (o_ex_rd != 5'd0) & w_id_valid &
                        ((w_rs1_used & (w_rs1 == o_ex_rd)) | (w_rs2_used & (w_rs2 == o_ex_rd)));
    assign w_advance  = ~i_flush & ~i_ex_hold & ~w_hazard;
    assign w_load     = w_advance & w_issue;

    // Next-state and IF/ID stall; priority flush > hold > hazard > advance
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        o_stall_ifid    = 1'b0;
        if (i_flush) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (i_ex_hold) begin
            o_stall_ifid = 1'b1;
        end else if (w_hazard) begin
            o_stall_ifid = 1'b1;
            w_state_nxt  = ST_STALL;
        end else begin
            case (r_state)
                ST_RUN:   w_state_nxt = ST_RUN;
                ST_STALL: w_state_nxt = ST_RUN;
                ST_FLUSH: begin
                    if (r_flush_cnt == 3'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    end
                end
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM state and flush-recovery counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // ID/EX control bundle; anything not issued becomes an all-zero bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal      <= 1'b0;
            o_ex_valid     <= 1'b0;
            o_ex_rd        <= 5'd0;
            o_ex_rs1       <= 5'd0;
            o_ex_rs2       <= 5'd0;
            o_ex_funct3    <= 3'd0;
            o_ex_reg_we    <= 1'b0;
            o_ex_mem_re    <= 1'b0;
            o_ex_mem_we    <= 1'b0;
            o_ex_alu_imm   <= 1'b0;
            o_ex_is_branch <= 1'b0;
            o_ex_is_jalr   <= 1'b0;
        end else if (i_ex_hold && !i_flush) begin
            o_illegal <= 1'b0;
        end else begin
            o_illegal      <= w_advance & w_illegal;
            o_ex_valid     <= w_load;
            o_ex_rd        <= w_load ? w_rd     : 5'd0;
            o_ex_rs1       <= w_load ? w_rs1    : 5'd0;
            o_ex_rs2       <= w_load ? w_rs2    : 5'd0;
            o_ex_funct3    <= w_load ? w_funct3 : 3'd0;
            o_ex_reg_we    <= w_load & w_dec_reg_we & (w_rd != 5'd0);
            o_ex_mem_re    <= w_load & w_dec_mem_re;
            o_ex_mem_we    <= w_load & w_dec_mem_we;
            o_ex_alu_imm   <= w_load & w_dec_alu_imm;
            o_ex_is_branch <= w_load & w_dec_branch;
            o_ex_is_jalr   <= w_load & w_dec_jalr;
        end
    end

    // Saturating count of IF/ID stall cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (o_stall_ifid && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end else begin
            o_stall_cnt <= o_stall_cnt;
        end
    end

endmodule

// File: tb/tb_rv_id_ctrl.sv
// Self-checking bench for rv_id_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.

module tb_rv_id_ctrl;
    import rv_id_ctrl_pkg::*;

    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] f3;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       alu_imm;
        logic       br;
        logic       jalr;
    } ex_t;

    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD   = 32'h00728333;
    localparam logic [31:0] I_SW    = 32'h0021A423;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_LWX0  = 32'h0000A003;
    localparam logic [31:0] I_ADD60 = 32'h00000333;
    localparam logic [31:0] I_ADD00 = 32'h00000033;

    localparam ex_t EX_BUB   = '0;
    localparam ex_t EX_LW    = '{valid:1'b1, rd:5'd5, rs1:5'd1, f3:3'd2, reg_we:1'b1, mem_re:1'b1, alu_imm:1'b1, default:'0};
    localparam ex_t EX_ADD   = '{valid:1'b1, rd:5'd6, rs1:5'd5, rs2:5'd7, reg_we:1'b1, default:'0};
    localparam ex_t EX_SW    = '{valid:1'b1, rd:5'd8, rs1:5'd3, rs2:5'd2, f3:3'd2, mem_we:1'b1, alu_imm:1'b1, default:'0};
    localparam ex_t EX_BEQ   = '{valid:1'b1, rd:5'd8, rs1:5'd1, rs2:5'd2, br:1'b1, default:'0};
    localparam ex_t EX_LUI   = '{valid:1'b1, rd:5'd5, rs1:5'd8, rs2:5'd3, f3:3'd5, reg_we:1'b1, alu_imm:1'b1, default:'0};
    localparam ex_t EX_JALR  = '{valid:1'b1, rd:5'd1, rs1:5'd1, reg_we:1'b1, alu_imm:1'b1, jalr:1'b1, default:'0};
    localparam ex_t EX_ADDI  = '{valid:1'b1, rd:5'd1, rs2:5'd1, reg_we:1'b1, alu_imm:1'b1, default:'0};
    localparam ex_t EX_LWX0  = '{valid:1'b1, rs1:5'd1, f3:3'd2, mem_re:1'b1, alu_imm:1'b1, default:'0};
    localparam ex_t EX_ADD60 = '{valid:1'b1, rd:5'd6, reg_we:1'b1, default:'0};
    localparam ex_t EX_ADD00 = '{valid:1'b1, default:'0};

    localparam logic [6:0] OP_TAB [12] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                                           7'h63, 7'h67, 7'h6F, 7'h7F, 7'h0B, 7'h00};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [31:0]      id_instr = 32'd0;
    logic             ex_hold = 1'b0;
    logic             flush = 1'b0;
    immext_ctrl_e     immext;
    logic             stall_ifid;
    logic             illegal;
    logic             ex_valid;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2;
    logic [2:0]       ex_funct3;
    logic             ex_reg_we, ex_mem_re, ex_mem_we, ex_alu_imm, ex_is_branch, ex_is_jalr;
    logic [CNT_W-1:0] stall_cnt;
    ex_t              dut_ex;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_id_ctrl #(.XLEN(32), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_instr(id_instr),
        .i_ex_hold(ex_hold), .i_flush(flush), .o_id_immext_ctrl(immext),
        .o_stall_ifid(stall_ifid), .o_illegal(illegal), .o_ex_valid(ex_valid),
        .o_ex_rd(ex_rd), .o_ex_rs1(ex_rs1), .o_ex_rs2(ex_rs2), .o_ex_funct3(ex_funct3),
        .o_ex_reg_we(ex_reg_we), .o_ex_mem_re(ex_mem_re), .o_ex_mem_we(ex_mem_we),
        .o_ex_alu_imm(ex_alu_imm), .o_ex_is_branch(ex_is_branch), .o_ex_is_jalr(ex_is_jalr),
        .o_stall_cnt(stall_cnt)
    );

    assign dut_ex = {ex_valid, ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_reg_we,
                     ex_mem_re, ex_mem_we, ex_alu_imm, ex_is_branch, ex_is_jalr};

    task automatic drive(input logic v, input logic [31:0] ins, input logic h, input logic f);
        id_valid = v; id_instr = ins; ex_hold = h; flush = f;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        checks++; if (dut_ex !== EX_BUB) begin failures++; $display("FAIL rst_bundle: got %h want %h", dut_ex, EX_BUB); end
        checks++; if (illegal !== 1'b0 || stall_cnt !== '0) begin failures++; $display("FAIL rst_misc: got ill=%0b cnt=%0d want 0 0", illegal, stall_cnt); end
        @(negedge clk); rst_n = 1'b1; step();
        drive(1'b1, I_LW, 1'b0, 1'b0); step();
        drive(1'b1, I_ADD, 1'b0, 1'b0); settle();
        checks++; if (stall_ifid !== 1'b1) begin failures++; $display("FAIL rst_pre_stall: got %0b want 1", stall_ifid); end
        step();
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL rst_pre_cnt: got %0d want 1", stall_cnt); end
        #2 rst_n = 1'b0; #1;
        checks++; if (dut_ex !== EX_BUB || stall_cnt !== '0 || illegal !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got ex=%h cnt=%0d ill=%0b want 0", dut_ex, stall_cnt, illegal); end
        @(negedge clk); rst_n = 1'b1; settle();
        checks++; if (stall_ifid !== 1'b0) begin failures++; $display("FAIL rst_release_stall: got %0b want 0", stall_ifid); end
        step();
        checks++; if (dut_ex !== EX_ADD) begin failures++; $display("FAIL rst_release_issue: got %h want %h", dut_ex, EX_ADD); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, I_LW, 1'b0, 1'b0); settle();
        checks++; if (stall_ifid !== 1'b0 || immext !== IMM_I) begin failures++; $display("FAIL lu_lw_comb: got st=%0b imm=%0d want 0 %0d", stall_ifid, immext, IMM_I); end
        step();
        checks++; if (dut_ex !== EX_LW) begin failures++; $display("FAIL lu_lw_ex: got %h want %h", dut_ex, EX_LW); end
        drive(1'b1, I_ADD, 1'b0, 1'b0); settle();
        checks++; if (stall_ifid !== 1'b1) begin failures++; $display("FAIL lu_hazard: got %0b want 1", stall_ifid); end
        step();
        checks++; if (dut_ex !== EX_BUB || stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_bubble: got ex=%h cnt=%0d want 0 1", dut_ex, stall_cnt); end
        settle();
        checks++; if (stall_ifid !== 1'b0) begin failures++; $display("FAIL lu_reissue_stall: got %0b want 0", stall_ifid); end
        step();
        checks++; if (dut_ex !== EX_ADD || stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_add_ex: got ex=%h cnt=%0d want %h 1", dut_ex, stall_cnt, EX_ADD); end
    endtask

    task automatic test_decode();
        do_reset();
        drive(1'b1, I_SW, 1'b0, 1'b0); settle();
        checks++; if (immext !== IMM_S) begin failures++; $display("FAIL dec_sw_imm: got %0d want %0d", immext, IMM_S); end
        step();
        checks++; if (dut_ex !== EX_SW) begin failures++; $display("FAIL dec_sw_ex: got %h want %h", dut_ex, EX_SW); end
        drive(1'b1, I_BEQ, 1'b0, 1'b0); settle();
        checks++; if (immext !== IMM_B) begin failures++; $display("FAIL dec_beq_imm: got %0d want %0d", immext, IMM_B); end
        step();
        checks++; if (dut_ex !== EX_BEQ) begin failures++; $display("FAIL dec_beq_ex: got %h want %h", dut_ex, EX_BEQ); end
        drive(1'b1, I_LUI, 1'b0, 1'b0); settle();
        checks++; if (immext !== IMM_U) begin failures++; $display("FAIL dec_lui_imm: got %0d want %0d", immext, IMM_U); end
        step();
        checks++; if (dut_ex !== EX_LUI) begin failures++; $display("FAIL dec_lui_ex: got %h want %h", dut_ex, EX_LUI); end
        drive(1'b1, I_JALR, 1'b0, 1'b0); settle();
        checks++; if (immext !== IMM_I) begin failures++; $display("FAIL dec_jalr_imm: got %0d want %0d", immext, IMM_I); end
        step();
        checks++; if (dut_ex !== EX_JALR) begin failures++; $display("FAIL dec_jalr_ex: got %h want %h", dut_ex, EX_JALR); end
        drive(1'b1, I_JAL, 1'b0, 1'b0); step();
        checks++; if (dut_ex !== EX_BUB || illegal !== 1'b0) begin failures++; $display("FAIL dec_jal_bubble: got ex=%h ill=%0b want 0 0", dut_ex, illegal); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, I_ADDI, 1'b0, 1'b1); settle();
        checks++; if (stall_ifid !== 1'b0) begin failures++; $display("FAIL fl_stall: got %0b want 0", stall_ifid); end
        step();
        drive(1'b1, I_ADDI, 1'b0, 1'b0);
        for (int i = 0; i < FLUSH_CYC + 1; i++) begin
            checks++; if (dut_ex !== EX_BUB) begin failures++; $display("FAIL fl_bubble%0d: got %h want 0", i, dut_ex); end
            if (i < FLUSH_CYC) step();
        end
        step();
        checks++; if (dut_ex !== EX_ADDI) begin failures++; $display("FAIL fl_resume: got %h want %h", dut_ex, EX_ADDI); end
        drive(1'b1, I_LW, 1'b0, 1'b0); step();
        drive(1'b1, I_ADD, 1'b0, 1'b1); settle();
        checks++; if (stall_ifid !== 1'b0) begin failures++; $display("FAIL fl_hz_stall: got %0b want 0", stall_ifid); end
        step();
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        checks++; if (dut_ex !== EX_BUB) begin failures++; $display("FAIL fl_hz_bubble: got %h want 0", dut_ex); end
        repeat (FLUSH_CYC + 1) step();
        checks++; if (dut_ex !== EX_ADD || stall_cnt !== 4'd0) begin failures++; $display("FAIL fl_hz_resume: got ex=%h cnt=%0d want %h 0", dut_ex, stall_cnt, EX_ADD); end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, I_ADDI, 1'b0, 1'b0); step();
        drive(1'b1, I_ADD, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (stall_ifid !== 1'b1) begin failures++; $display("FAIL hold_stall%0d: got %0b want 1", i, stall_ifid); end
            step();
            checks++; if (dut_ex !== EX_ADDI) begin failures++; $display("FAIL hold_frozen%0d: got %h want %h", i, dut_ex, EX_ADDI); end
        end
        checks++; if (stall_cnt !== 4'd4) begin failures++; $display("FAIL hold_cnt: got %0d want 4", stall_cnt); end
        drive(1'b1, I_ADD, 1'b0, 1'b0); step();
        checks++; if (dut_ex !== EX_ADD || stall_cnt !== 4'd4) begin failures++; $display("FAIL hold_release: got ex=%h cnt=%0d want %h 4", dut_ex, stall_cnt, EX_ADD); end
    endtask

    task automatic test_illegal_x0();
        do_reset();
        drive(1'b1, I_ILL, 1'b0, 1'b0); step();
        checks++; if (dut_ex !== EX_BUB || illegal !== 1'b1) begin failures++; $display("FAIL ill_pulse: got ex=%h ill=%0b want 0 1", dut_ex, illegal); end
        drive(1'b1, I_ADDI, 1'b0, 1'b0); step();
        checks++; if (dut_ex !== EX_ADDI || illegal !== 1'b0) begin failures++; $display("FAIL ill_clear: got ex=%h ill=%0b want %h 0", dut_ex, illegal, EX_ADDI); end
        drive(1'b1, I_ILL, 1'b1, 1'b0); step();
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_on_hold: got %0b want 0", illegal); end
        drive(1'b1, I_ILL, 1'b0, 1'b0); step();
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_after_hold: got %0b want 1", illegal); end
        drive(1'b1, I_LWX0, 1'b0, 1'b0); step();
        checks++; if (dut_ex !== EX_LWX0 || illegal !== 1'b0) begin failures++; $display("FAIL x0_lw: got ex=%h ill=%0b want %h 0", dut_ex, illegal, EX_LWX0); end
        drive(1'b1, I_ADD60, 1'b0, 1'b0); settle();
        checks++; if (stall_ifid !== 1'b0) begin failures++; $display("FAIL x0_nostall: got %0b want 0", stall_ifid); end
        step();
        checks++; if (dut_ex !== EX_ADD60) begin failures++; $display("FAIL x0_add6: got %h want %h", dut_ex, EX_ADD60); end
        drive(1'b1, I_ADD00, 1'b0, 1'b0); step();
        checks++; if (dut_ex !== EX_ADD00) begin failures++; $display("FAIL x0_add0: got %h want %h", dut_ex, EX_ADD00); end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1'b1, I_ADDI, 1'b1, 1'b0);
        repeat (20) step();
        checks++; if (stall_cnt !== CNT_MAX) begin failures++; $display("FAIL sat_cnt: got %0d want %0d", stall_cnt, CNT_MAX); end
    endtask

    function automatic ex_t model_decode(input logic [31:0] ins);
        ex_t        e;
        logic [6:0] op;
        op        = ins[6:0];
        e         = '0;
        e.valid   = 1'b1;
        e.rd      = ins[11:7];
        e.rs1     = ins[19:15];
        e.rs2     = ins[24:20];
        e.f3      = ins[14:12];
        e.reg_we  = (op inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67}) && (ins[11:7] != 5'd0);
        e.mem_re  = (op == 7'h03);
        e.mem_we  = (op == 7'h23);
        e.alu_imm = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h37, 7'h67};
        e.br      = (op == 7'h63);
        e.jalr    = (op == 7'h67);
        return e;
    endfunction

    function automatic immext_ctrl_e model_imm(input logic [6:0] op);
        if (op inside {7'h03, 7'h13, 7'h67}) return IMM_I;
        else if (op == 7'h23)                return IMM_S;
        else if (op == 7'h63)                return IMM_B;
        else                                 return IMM_U;
    endfunction

    task automatic test_random();
        ex_t              m_ex, n_ex;
        logic             m_ill, n_ill, m_held, hz, exp_st, eff, known;
        logic [CNT_W-1:0] m_cnt;
        int               flush_left;
        logic [6:0]       op;
        logic [31:0]      ins;
        do_reset();
        m_ex = '0; m_ill = 1'b0; m_cnt = '0; flush_left = 0; m_held = 1'b0; ins = 32'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!m_held) begin
                ins        = $urandom;
                ins[6:0]   = OP_TAB[$urandom_range(0, 11)];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                drive($urandom_range(0, 9) != 0, ins, 1'b0, 1'b0);
            end
            ex_hold = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            op    = ins[6:0];
            eff   = id_valid && (flush_left == 0);
            known = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
            hz    = m_ex.valid && m_ex.mem_re && (m_ex.rd != 5'd0) && eff &&
                    (((op inside {7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h67}) && ins[19:15] == m_ex.rd) ||
                     ((op inside {7'h23, 7'h33, 7'h63}) && ins[24:20] == m_ex.rd));
            exp_st = !flush && (ex_hold || hz);
            settle();
            checks++; if (stall_ifid !== exp_st) begin failures++; $display("FAIL rnd_stall c%0d: got %0b want %0b", cyc, stall_ifid, exp_st); end
            checks++; if (immext !== model_imm(op)) begin failures++; $display("FAIL rnd_imm c%0d: got %0d want %0d", cyc, immext, model_imm(op)); end
            n_ex = m_ex; n_ill = 1'b0;
            if (flush) begin
                n_ex = '0; flush_left = FLUSH_CYC;
            end else if (ex_hold) begin
                n_ex = m_ex;
            end else if (hz) begin
                n_ex = '0;
            end else begin
                n_ex  = (eff && known && op != 7'h6F) ? model_decode(ins) : ex_t'('0);
                n_ill = eff && !known;
                if (flush_left > 0) flush_left--;
            end
            if (exp_st && m_cnt != CNT_MAX) m_cnt++;
            m_ex = n_ex; m_ill = n_ill; m_held = exp_st;
            step();
            checks++; if (dut_ex !== m_ex) begin failures++; $display("FAIL rnd_ex c%0d: got %h want %h", cyc, dut_ex, m_ex); end
            checks++; if (illegal !== m_ill) begin failures++; $display("FAIL rnd_ill c%0d: got %0b want %0b", cyc, illegal, m_ill); end
            checks++; if (stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, stall_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_decode();
        test_flush();
        test_hold();
        test_illegal_x0();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
